// File: rtl/alu_cmd_sequencer.sv
// Issuing side of the 32-bit ALU: accepts one command, holds the ALU inputs stable, samples the
// result into a response slot and keeps a chaining accumulator. Optional saturation: ALU_SEQ_SAT_EN.
module alu_cmd_sequencer #(
  parameter int unsigned EXEC_WAIT = 1,
  parameter logic [31:0] ACC_INIT  = 32'h0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic        cmd_use_acc,
  input  logic        acc_clr,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_op2,
  output logic [3:0]  alu_opcode,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_ovf,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_ovf,
  output logic        rsp_illegal,
  output logic [31:0] acc
);

  localparam int unsigned DW  = 32;
  localparam int unsigned OPW = 4;
  localparam int unsigned CW  = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [OPW-1:0] OP_SRL  = 4'b0000;
  localparam logic [OPW-1:0] OP_SLL  = 4'b0001;
  localparam logic [OPW-1:0] OP_SRA  = 4'b0010;
  localparam logic [OPW-1:0] OP_SLA  = 4'b0011;
  localparam logic [OPW-1:0] OP_ADD  = 4'b0100;
  localparam logic [OPW-1:0] OP_SUB  = 4'b0101;
  localparam logic [OPW-1:0] OP_MUL  = 4'b0110;
  localparam logic [OPW-1:0] OP_AND  = 4'b1000;
  localparam logic [OPW-1:0] OP_OR   = 4'b1001;
  localparam logic [OPW-1:0] OP_NOR  = 4'b1010;
  localparam logic [OPW-1:0] OP_NAND = 4'b1011;
  localparam logic [OPW-1:0] OP_XOR  = 4'b1100;

  localparam logic [DW-1:0] SAT_POS = 32'h7FFF_FFFF;
  localparam logic [DW-1:0] SAT_NEG = 32'h8000_0000;
  localparam logic [CW-1:0] CNT_LAST = CW'(EXEC_WAIT - 1);

  logic [1:0]     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           cmd_ready_q, cmd_ready_d;
  logic [DW-1:0]  alu_op1_q, alu_op1_d;
  logic [DW-1:0]  alu_op2_q, alu_op2_d;
  logic [OPW-1:0] alu_opcode_q, alu_opcode_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]  rsp_result_q, rsp_result_d;
  logic           rsp_zero_q, rsp_zero_d;
  logic           rsp_ovf_q, rsp_ovf_d;
  logic           rsp_illegal_q, rsp_illegal_d;
  logic [DW-1:0]  acc_q, acc_d;

  logic           illegal_c;
  logic [DW-1:0]  sat_result_c;
  logic [DW-1:0]  final_result_c;
  logic           final_ovf_c;
  logic           unused_alu_zero;

  // Zero flag is rebuilt from the final result so it tracks saturation/illegal masking.
  assign unused_alu_zero = alu_zero;

  // Opcode legality of the command currently issued to the ALU.
  always_comb begin
    illegal_c = 1'b1;
    case (alu_opcode_q)
      OP_SRL, OP_SLL, OP_SRA, OP_SLA,
      OP_ADD, OP_SUB, OP_MUL,
      OP_AND, OP_OR, OP_NOR, OP_NAND, OP_XOR: illegal_c = 1'b0;
      default:                                 illegal_c = 1'b1;
    endcase
  end

`ifdef ALU_SEQ_SAT_EN
  // Clamp overflowing arithmetic toward the sign the true result would have had.
  always_comb begin
    sat_result_c = alu_result;
    if (alu_ovf) begin
      case (alu_opcode_q)
        OP_ADD, OP_SUB: sat_result_c = alu_op1_q[DW-1] ? SAT_NEG : SAT_POS;
        OP_MUL:         sat_result_c = (alu_op1_q[DW-1] ^ alu_op2_q[DW-1]) ? SAT_NEG : SAT_POS;
        default:        sat_result_c = alu_result;
      endcase
    end
  end
`else
  assign sat_result_c = alu_result;
`endif

  assign final_result_c = illegal_c ? '0 : sat_result_c;
  assign final_ovf_c    = illegal_c ? 1'b0 : alu_ovf;

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    alu_op1_d     = alu_op1_q;
    alu_op2_d     = alu_op2_q;
    alu_opcode_d  = alu_opcode_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_result_d  = rsp_result_q;
    rsp_zero_d    = rsp_zero_q;
    rsp_ovf_d     = rsp_ovf_q;
    rsp_illegal_d = rsp_illegal_q;
    acc_d         = acc_q;
    cmd_ready_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          alu_op1_d    = cmd_use_acc ? acc_q : cmd_a;
          alu_op2_d    = cmd_b;
          alu_opcode_d = cmd_op;
          cnt_d        = '0;
          state_d      = S_EXEC;
        end
      end
      S_EXEC: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          rsp_valid_d   = 1'b1;
          rsp_result_d  = final_result_c;
          rsp_zero_d    = (final_result_c == '0);
          rsp_ovf_d     = final_ovf_c;
          rsp_illegal_d = illegal_c;
          if (!illegal_c) begin
            acc_d = final_result_c;
          end
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase

    // Clear beats a same-edge sample update; latched alu_op1 is left alone.
    if (acc_clr) begin
      acc_d = ACC_INIT;
    end
    cmd_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      cmd_ready_q   <= 1'b1;
      alu_op1_q     <= '0;
      alu_op2_q     <= '0;
      alu_opcode_q  <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= '0;
      rsp_zero_q    <= 1'b0;
      rsp_ovf_q     <= 1'b0;
      rsp_illegal_q <= 1'b0;
      acc_q         <= ACC_INIT;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cmd_ready_q   <= cmd_ready_d;
      alu_op1_q     <= alu_op1_d;
      alu_op2_q     <= alu_op2_d;
      alu_opcode_q  <= alu_opcode_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_result_q  <= rsp_result_d;
      rsp_zero_q    <= rsp_zero_d;
      rsp_ovf_q     <= rsp_ovf_d;
      rsp_illegal_q <= rsp_illegal_d;
      acc_q         <= acc_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign alu_op1     = alu_op1_q;
  assign alu_op2     = alu_op2_q;
  assign alu_opcode  = alu_opcode_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_zero    = rsp_zero_q;
  assign rsp_ovf     = rsp_ovf_q;
  assign rsp_illegal = rsp_illegal_q;
  assign acc         = acc_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with a behavioural 32-bit ALU attached to its alu_* port.
module tb_alu_cmd_sequencer;

  localparam int unsigned EXEC_WAIT = 1;
  localparam logic [31:0] ACC_INIT  = 32'h0000_00A5;

  localparam logic [3:0] OP_SRL = 4'b0000, OP_SLL = 4'b0001, OP_SRA = 4'b0010, OP_SLA = 4'b0011;
  localparam logic [3:0] OP_ADD = 4'b0100, OP_SUB = 4'b0101, OP_MUL = 4'b0110;
  localparam logic [3:0] OP_AND = 4'b1000, OP_OR = 4'b1001, OP_NOR = 4'b1010;
  localparam logic [3:0] OP_NAND = 4'b1011, OP_XOR = 4'b1100;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic        ovf;
    logic        ill;
    logic [31:0] acc;
  } exp_t;

  logic        clk, resetn;
  logic        cmd_valid, cmd_ready, cmd_use_acc, acc_clr;
  logic [3:0]  cmd_op, alu_opcode;
  logic [31:0] cmd_a, cmd_b, alu_op1, alu_op2, alu_result, rsp_result, acc;
  logic        alu_zero, alu_ovf;
  logic        rsp_valid, rsp_ready, rsp_zero, rsp_ovf, rsp_illegal;

  int          n_checks = 0;
  int          n_errors = 0;
  exp_t        sb[$];
  logic [31:0] model_acc;

  alu_cmd_sequencer #(.EXEC_WAIT(EXEC_WAIT), .ACC_INIT(ACC_INIT)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc), .acc_clr(acc_clr),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_ovf(alu_ovf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf), .rsp_illegal(rsp_illegal), .acc(acc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: {ovf, result}; undefined opcodes return junk so masking is visible.
  function automatic logic [32:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic [63:0] p;
    logic        o;
    o = 1'b0;
    case (op)
      OP_SRL:  r = a >> b;
      OP_SLL:  r = a << b;
      OP_SRA:  r = 32'($signed(a) >>> b);
      OP_SLA:  r = a <<< b;
      OP_ADD:  begin r = a + b; o = (a[31] == b[31]) && (r[31] != a[31]); end
      OP_SUB:  begin r = a - b; o = (a[31] != b[31]) && (r[31] != a[31]); end
      OP_MUL:  begin
        p = 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
        r = p[31:0];
        o = (p != {{32{p[31]}}, p[31:0]});
      end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_NOR:  r = ~(a | b);
      OP_NAND: r = ~(a & b);
      OP_XOR:  r = a ^ b;
      default: begin r = 32'hDEAD_BEEF; o = 1'b1; end
    endcase
    return {o, r};
  endfunction

  always_comb begin
    {alu_ovf, alu_result} = alu_f(alu_opcode, alu_op1, alu_op2);
    alu_zero = (alu_result == 32'h0);
  end

  function automatic logic legal_f(input logic [3:0] op);
    return (op <= OP_MUL) || (op >= OP_AND && op <= OP_XOR);
  endfunction

  function automatic exp_t expect_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [32:0] ar;
    ar    = alu_f(op, a, b);
    e.ill = !legal_f(op);
    e.res = ar[31:0];
    e.ovf = ar[32];
`ifdef ALU_SEQ_SAT_EN
    if (e.ovf && (op == OP_ADD || op == OP_SUB)) e.res = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    else if (e.ovf && op == OP_MUL) e.res = (a[31] ^ b[31]) ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    if (e.ill) begin
      e.res = 32'h0;
      e.ovf = 1'b0;
    end
    e.zero = (e.res == 32'h0);
    e.acc  = 32'h0;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Response monitor: pops one expectation per accepted response.
  always @(negedge clk) begin
    if (resetn && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_result", rsp_result, e.res);
        check("rsp_zero", 32'(rsp_zero), 32'(e.zero));
        check("rsp_ovf", 32'(rsp_ovf), 32'(e.ovf));
        check("rsp_illegal", 32'(rsp_illegal), 32'(e.ill));
        check("acc", acc, e.acc);
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(n < 50), 32'd1);
  endtask

  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic use_acc, input logic clr, input int hold);
    exp_t        e;
    logic [31:0] op1, r0;
    int          n;
    wait_ready();
    rsp_ready   = (hold == 0);
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_a       = a;
    cmd_b       = b;
    cmd_use_acc = use_acc;
    op1         = use_acc ? model_acc : a;
    e           = expect_f(op, op1, b);
    model_acc   = clr ? ACC_INIT : (e.ill ? model_acc : e.res);
    e.acc       = model_acc;
    @(posedge clk);
    sb.push_back(e);
    #1;
    cmd_valid = 1'b0;
    cmd_a     = 32'hFFFF_FFFF;
    cmd_b     = 32'hFFFF_FFFF;
    acc_clr   = clr;
    check("alu_op1", alu_op1, op1);
    check("alu_op2", alu_op2, b);
    check("alu_opcode", 32'(alu_opcode), 32'(op));
    check("ready_low", 32'(cmd_ready), 32'd0);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
      if (n == int'(EXEC_WAIT)) acc_clr = 1'b0;
    end while (!rsp_valid && n < 50);
    acc_clr = 1'b0;
    check("latency", 32'(n), 32'(EXEC_WAIT));
    if (hold > 0) begin
      r0 = rsp_result;
      repeat (hold) begin
        @(posedge clk);
        #1;
        check("hold_valid", 32'(rsp_valid), 32'd1);
        check("hold_result", rsp_result, r0);
        check("hold_ready", 32'(cmd_ready), 32'd0);
        check("hold_op1", alu_op1, op1);
      end
      rsp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check("rsp_drop", 32'(rsp_valid), 32'd0);
    check("ready_back", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0]  ops[12];
    logic [31:0] as[12], bs[12];
    ops = '{OP_AND, OP_OR, OP_NOR, OP_NAND, OP_XOR, OP_MUL, OP_SRL, OP_SLL, OP_SRA, OP_SLA, OP_SUB, 4'b0111};
    as  = '{32'hF0F0_1234, 32'h0F00_0001, 32'h1234_5678, 32'hFFFF_0000, 32'hAAAA_5555,
            32'h8000_0000, 32'h8000_0010, 32'h0000_0001, 32'h8000_0000, 32'h0000_0003,
            32'h8000_0000, 32'h0000_0009};
    bs  = '{32'hFF00_FF00, 32'h00F0_0002, 32'h0000_FFFF, 32'hFF00_FF00, 32'h5555_5555,
            32'h0000_0002, 32'h0000_0004, 32'h0000_0028, 32'h0000_0004, 32'h0000_0002,
            32'h0000_0001, 32'h0000_0003};

    resetn = 1'b0; cmd_valid = 1'b0; cmd_op = 4'h0; cmd_a = 32'h0; cmd_b = 32'h0;
    cmd_use_acc = 1'b0; acc_clr = 1'b0; rsp_ready = 1'b1;
    model_acc = ACC_INIT;
    #12;
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_acc", acc, ACC_INIT);
    check("rst_op1", alu_op1, 32'h0);
    check("rst_result", rsp_result, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(cmd_ready), 32'd1);

    send(OP_ADD, 32'd5, 32'd7, 1'b0, 1'b0, 0);
    send(OP_SUB, 32'h0, 32'd12, 1'b1, 1'b0, 0);
    send(OP_ADD, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 0);
    send(4'b1111, 32'd3, 32'd4, 1'b0, 1'b0, 0);
    send(OP_ADD, 32'h0, 32'h0, 1'b1, 1'b0, 0);
    send(OP_ADD, 32'd1, 32'd2, 1'b0, 1'b1, 5);
    for (int i = 0; i < 12; i++) send(ops[i], as[i], bs[i], 1'b0, 1'b0, 0);
    send(OP_XOR, 32'h0, 32'h0000_F00F, 1'b1, 1'b0, 0);

    // Reset asserted while the command is in EXEC.
    wait_ready();
    cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_a = 32'd100; cmd_b = 32'd1; cmd_use_acc = 1'b0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    resetn = 1'b0;
    #1;
    check("mid_rst_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_op1", alu_op1, 32'h0);
    check("mid_rst_op2", alu_op2, 32'h0);
    check("mid_rst_opcode", 32'(alu_opcode), 32'd0);
    check("mid_rst_acc", acc, ACC_INIT);
    check("mid_rst_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    resetn = 1'b1;
    model_acc = ACC_INIT;
    send(OP_ADD, 32'h0, 32'd1, 1'b1, 1'b0, 0);

    repeat (3) @(negedge clk);
    check("sb_left", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
